// File: rtl/crc8.sv
// crc8: CRC-8 (SMBUS style, MSB-first, no reflection, no final XOR) over an
// 80-bit message, processed one byte per clock.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse, accepted only while idle
//   data_in  [0:79] message, data_in[0] is the first (most significant) bit
//   crc      [0:7] registered result, crc[0] is the x^7 coefficient
//   busy     high while a computation is in progress
//   done     one-cycle pulse when crc has just been updated
module crc8 #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:79] data_in,
    output logic [0:7]  crc,
    output logic        busy,
    output logic        done
);

    localparam int unsigned MSG_W   = 80;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_BYTES = MSG_W / BYTE_W;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [0:MSG_W-1]      data_q, data_d;
    logic [BYTE_W-1:0]     acc_q, acc_d;
    logic [BYTE_W-1:0]     crc_q, crc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BYTE_W-1:0]     acc_next;

    // Eight MSB-first bit steps unrolled into one combinational byte update.
    function automatic logic [BYTE_W-1:0] crc_byte(input logic [BYTE_W-1:0] c,
                                                   input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        logic              fb;
        r = c;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            fb = r[BYTE_W-1] ^ b[i];
            r  = {r[BYTE_W-2:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return r;
    endfunction

    // The latched message shifts toward index 0, so the current byte is
    // always the top eight bits.
    always_comb begin
        acc_next = crc_byte(acc_q, data_q[0:BYTE_W-1]);
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        acc_d   = acc_q;
        crc_d   = crc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    data_d  = data_in;
                    acc_d   = INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d  = acc_next;
                data_d = data_q << BYTE_W;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BYTE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    crc_d   = acc_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            crc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            crc_q   <= crc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // crc[0] maps to the x^7 coefficient.
    assign crc  = crc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_crc8.sv
// tb_crc8: randomized self-checking bench for crc8 against a polynomial
// long-division reference model.
module tb_crc8;

    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [0:79] data_in;
    logic [0:7]  crc;
    logic        busy;
    logic        done;

    int checks;
    int failures;
    logic [7:0] last_crc;

    crc8 #(.POLY(POLY), .INIT(INIT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .crc     (crc),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Remainder of (message * x^8) divided by x^8 + POLY; INIT folds into the
    // first eight message bits.
    function automatic logic [7:0] ref_crc(input logic [79:0] msg);
        logic [87:0] r;
        r = {msg, 8'h00};
        r[87:80] = r[87:80] ^ INIT;
        for (int i = 87; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY};
        end
        return r[7:0];
    endfunction

    function automatic logic [79:0] rand_msg();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // One full computation; optionally pokes start and scrambles data_in
    // while busy to show both are ignored.
    task automatic do_run(input logic [79:0] msg, input bit disturb, input string tag);
        logic [7:0] exp;
        exp = ref_crc(msg);
        @(negedge clk);
        data_in = msg;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            check_eq({tag, "_nodone"}, 32'(done), 32'd0);
            check_eq({tag, "_hold"}, 32'(crc), 32'(last_crc));
            if (disturb) begin
                data_in = rand_msg();
                start   = 1'(i % 2);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_crc"}, 32'(crc), 32'(exp));
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_keep"}, 32'(crc), 32'(exp));
        check_eq({tag, "_nostart"}, 32'(busy), 32'd0);
        last_crc = exp;
    endtask

    initial begin
        logic [79:0] msg_a, msg_b;
        logic [7:0]  exp_a, exp_b;
        checks   = 0;
        failures = 0;
        last_crc = 8'h00;
        rst_n    = 1'b0;
        start    = 1'b0;
        data_in  = '0;

        #1;
        check_eq("rst_crc", 32'(crc), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_run(80'h0, 1'b0, "zero");
        check_eq("zero_const", 32'(last_crc), 32'h00);
        do_run(80'h00_31_32_33_34_35_36_37_38_39, 1'b0, "check");
        check_eq("check_const", 32'(crc), 32'hF4);
        do_run(80'h01, 1'b0, "one");
        check_eq("one_const", 32'(crc), 32'h07);
        do_run(80'h80, 1'b0, "h80");
        check_eq("h80_const", 32'(crc), 32'h89);
        do_run(80'h0000_0000_0001_DC38_51DD, 1'b1, "dec");

        // Random messages, half with busy-time disturbance.
        for (int n = 0; n < 20; n++) begin
            do_run(rand_msg(), 1'(n % 2), "rnd");
        end

        // Reset in the middle of a run.
        msg_a = rand_msg();
        @(negedge clk);
        data_in = msg_a;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_crc", 32'(crc), 32'h00);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check_eq("abort_nodone", 32'(done), 32'd0);
            check_eq("abort_nobusy", 32'(busy), 32'd0);
        end
        last_crc = 8'h00;
        do_run(rand_msg(), 1'b0, "postrst");

        // Start held high: back-to-back runs, data changing in between.
        msg_a = rand_msg();
        msg_b = rand_msg();
        exp_a = ref_crc(msg_a);
        exp_b = ref_crc(msg_b);
        @(negedge clk);
        data_in = msg_a;
        start   = 1'b1;
        @(posedge clk); #1;
        data_in = msg_b;
        repeat (10) @(posedge clk);
        #1;
        check_eq("b2b_done_a", 32'(done), 32'd1);
        check_eq("b2b_crc_a", 32'(crc), 32'(exp_a));
        @(posedge clk); #1;
        check_eq("b2b_restart", 32'(busy), 32'd1);
        check_eq("b2b_pulse_a", 32'(done), 32'd0);
        data_in = rand_msg();
        start   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("b2b_done_b", 32'(done), 32'd1);
        check_eq("b2b_crc_b", 32'(crc), 32'(exp_b));
        @(posedge clk); #1;
        check_eq("b2b_pulse_b", 32'(done), 32'd0);
        check_eq("b2b_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc8.md
CRC8 -- requirements
Module: crc8

Interface
REQ-001 Parameter POLY, default 8'h07, generator polynomial x^8+x^2+x+1 with the x^8 term implicit.
REQ-002 Parameter INIT, default 8'h00, initial CRC register value loaded on each start.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-006 data_in  input  80, declared [0:79]  message; data_in[0] is the first bit transmitted (MSB of the message).
REQ-007 crc  output  8, declared [0:7]  registered result; crc[0] is the CRC MSB (x^7 coefficient).
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse marking crc as newly valid.

Function
REQ-010 The CRC algorithm SHALL be CRC-8/SMBUS style: polynomial POLY, initial value INIT, no input or output reflection, no final XOR.
- The message is fed MSB-first: data_in[0] first, data_in[79] last.
REQ-011 The block SHALL process the message as 10 bytes, one byte per clock.
- Byte k = data_in[8k : 8k+7], for k = 0..9.
- Byte 0 is processed first.
- Bit data_in[8k] is the MSB of byte k.
REQ-012 The per-byte update SHALL equal eight successive MSB-first bit steps.
- Each step: fb = crc_reg[7] XOR bit; crc_reg = (crc_reg << 1) XOR (fb ? POLY : 0).
- The update SHALL be implemented as combinational byte-wide logic.
REQ-013 States: IDLE and RUN.
- IDLE -> RUN when start=1 is sampled; data_in is latched, crc_reg = INIT, byte counter = 0.
- In RUN, each clock processes byte[counter] and increments the counter.
- After the edge that processes byte 9, go to IDLE.
REQ-014 Latency: with start sampled on edge E0, bytes are processed on edges E1..E10.
- busy SHALL be 1 from after E0 until after E10.
- done SHALL be 1 for exactly the cycle following E10.
- crc SHALL present the final value from E10 onward.
REQ-015 crc SHALL update only at completion (edge E10) and SHALL hold the previous result while busy and while idle.
REQ-016 start asserted while busy=1 SHALL be ignored; it has no effect on the running computation and is not queued.
REQ-017 start sampled in the cycle where done=1 SHALL be accepted (busy is already 0), beginning a new computation.
REQ-018 data_in changes after E0 SHALL NOT affect the running computation.
REQ-019 start held high continuously SHALL yield back-to-back computations, each 11 cycles apart, each using data_in as sampled at its own start edge.

Reset
REQ-020 While rst_n=0, the block SHALL immediately and asynchronously force: crc=8'h00, busy=0, done=0, state IDLE, counter 0, latched data 0.
REQ-021 Reset asserted mid-computation SHALL abort it.
- No done pulse SHALL follow.
- The first start after rst_n deasserts SHALL begin a fresh computation.
REQ-022 Release of rst_n SHALL be synchronous to clk; the first start is recognised on the first rising edge after release.

Verification
REQ-023 data_in=80'h0, start pulse -> busy high 10 cycles, then done pulse with crc=8'h00.
REQ-024 data_in=80'h00_31_32_33_34_35_36_37_38_39 ("123456789" after a leading zero byte) -> crc=8'hF4 at done.
REQ-025 data_in=80'h01 -> crc=8'h07; data_in=80'h80 -> crc=8'h89.
REQ-026 data_in=80'd7989645789 (bytes 00 00 00 00 00 01 DC 38 51 DD) -> crc SHALL match the bitwise reference model of REQ-012 applied to data_in[0..79]; start pulses during busy SHALL be ignored.
REQ-027 Assert rst_n=0 on cycle 5 of a run -> crc=00, busy=0, done=0 immediately, with no later done pulse; a new start then returns a correct result.
REQ-028 start held high across two runs with data_in changing between them -> two done pulses 11 cycles apart, each crc matching its own sampled data_in.
